alu_arbiter: RTL and testbench

- Shares the single 64-bit ALU_64 datapath between two requesters (e.g. execute stage and address-generation/branch-compare unit).
- Round-robin arbitration with valid/ready request handshake.
- Result is captured into a one-entry output buffer, returned with the requester ID and held under valid/ready backpressure.
- Sits between the control/execute logic and ALU_64.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_arbiter_if.sv | 27 ++
 rtl/ALU_64.sv | 33 +++
 rtl/alu_arb_rr_picker.sv | 30 +++
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings, legal-op check and arbiter state type
// for the ALU_64 arbiter slice.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } arb_state_t;

  function automatic logic is_legal_op(input logic [3:0] ctrl);
    return (ctrl == ALU_AND) || (ctrl == ALU_OR) || (ctrl == ALU_ADD) ||
           (ctrl == ALU_SUB) || (ctrl == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters, the result consumer and alu_arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 4
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*WIDTH-1:0]  req_a;
  logic [2*WIDTH-1:0]  req_b;
  logic [2*CTRL_W-1:0] req_ctrl;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [WIDTH-1:0]    rsp_out;
  logic                rsp_zero;
  logic                rsp_illegal;

  modport master (
    output req_valid, req_a, req_b, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_illegal
  );

  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_illegal
  );
endinterface

// File: rtl/ALU_64.sv
// Combinational 64-bit ALU: AND/OR/ADD/SUB/SLT; unknown controls yield zero outputs.
module ALU_64
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALU_out,
  output logic             zero
);

  always_comb begin
    ALU_out = '0;
    zero    = 1'b0;
    case (ALU_control)
      ALU_AND: ALU_out = A & B;
      ALU_OR:  ALU_out = A | B;
      ALU_ADD: ALU_out = A + B;
      ALU_SUB: begin
        ALU_out = A - B;
        zero    = (A == B);
      end
      ALU_SLT: begin
        ALU_out[0] = $signed(A) < $signed(B);
        zero       = $signed(A) < $signed(B);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arb_rr_picker.sv
// Two-way round-robin grant: under contention the requester other than 'last' wins.
module alu_arb_rr_picker (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant,
  output logic       grant_id
);

  always_comb begin
    grant    = '0;
    grant_id = 1'b0;
    case (valid)
      2'b01: grant = 2'b01;
      2'b10: begin
        grant    = 2'b10;
        grant_id = 1'b1;
      end
      2'b11: begin
        if (last) begin
          grant = 2'b01;
        end else begin
          grant    = 2'b10;
          grant_id = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU_64 between two requesters with a one-entry result buffer.
// Optional perf counters enabled by defining ALU_ARB_PERF_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 4
) (
  input  logic clk,
  input  logic reset,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0] perf_grant0,
  output logic [31:0] perf_grant1,
  output logic [31:0] perf_stall
`endif
);

  arb_state_t       state;
  logic             last;
  logic [1:0]       grant;
  logic             grant_id;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [CTRL_W-1:0] sel_ctrl;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             sel_illegal;

  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_out_q;
  logic             rsp_zero_q;
  logic             rsp_illegal_q;

  alu_arb_rr_picker u_picker (
    .valid    (bus.req_valid),
    .last     (last),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Reset gates acceptance so nothing is handed out while the buffer is being cleared.
  always_comb begin
    can_accept    = !reset && ((state == IDLE) || bus.rsp_ready);
    bus.req_ready = can_accept ? grant : 2'b00;
    accept        = |(bus.req_valid & bus.req_ready);
  end

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_ctrl = '0;
    if (|grant) begin
      sel_a    = bus.req_a[grant_id*WIDTH +: WIDTH];
      sel_b    = bus.req_b[grant_id*WIDTH +: WIDTH];
      sel_ctrl = bus.req_ctrl[grant_id*CTRL_W +: CTRL_W];
    end
    sel_illegal = !is_legal_op(sel_ctrl);
  end

  ALU_64 #(.WIDTH(WIDTH)) u_alu (
    .ALU_control (sel_ctrl),
    .A           (sel_a),
    .B           (sel_b),
    .ALU_out     (alu_out),
    .zero        (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last          <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_out_q     <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else if (accept) begin
      // Covers both IDLE fill and FULL overwrite when the consumer drains this cycle.
      state         <= FULL;
      last          <= grant_id;
      rsp_valid_q   <= 1'b1;
      rsp_id_q      <= grant_id;
      rsp_out_q     <= alu_out;
      rsp_zero_q    <= alu_zero;
      rsp_illegal_q <= sel_illegal;
    end else if (state == FULL && bus.rsp_ready) begin
      state       <= IDLE;
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_out     = rsp_out_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_illegal = rsp_illegal_q;

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept && !grant_id && perf_grant0 != '1) perf_grant0 <= perf_grant0 + 32'd1;
      if (accept && grant_id && perf_grant1 != '1)  perf_grant1 <= perf_grant1 + 32'd1;
      if (state == FULL && !bus.rsp_ready && |bus.req_valid && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a cycle-level scoreboard monitor.
module tb_alu_arbiter;

  localparam int W = 64;

  typedef struct {
    logic         id;
    logic [W-1:0] out;
    logic         zero;
    logic         illegal;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  exp_t q[$];
  logic exp_full = 1'b0;
  logic exp_last = 1'b1;
  logic mon_can;
  logic [1:0] mon_gnt;
  logic [1:0] mon_req_ready_exp;
  logic mon_id;
  exp_t mon_e;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W), .CTRL_W(4)) bus ();

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_stall;
`endif

  alu_arbiter #(.WIDTH(W), .CTRL_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grant0 (perf_grant0),
    .perf_grant1 (perf_grant1),
    .perf_stall  (perf_stall)
`endif
  );

  function automatic exp_t model(input logic id, input logic [3:0] c,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.id = id; e.out = '0; e.zero = 1'b0; e.illegal = 1'b0;
    case (c)
      4'b0000: e.out = a & b;
      4'b0001: e.out = a | b;
      4'b0010: e.out = a + b;
      4'b0110: begin e.out = a - b; e.zero = (a == b); end
      4'b0111: begin
        e.zero = ($signed(a) < $signed(b));
        e.out  = {{(W-1){1'b0}}, e.zero};
      end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  // Scoreboard: models grant/accept independently, pushes on accept, compares the buffered result.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (bus.req_ready !== 2'b00) begin
        failures++;
        $display("FAIL mon_ready_in_reset got=%b exp=00", bus.req_ready);
      end
      q.delete();
      exp_full = 1'b0;
      exp_last = 1'b1;
    end else begin
      mon_can = !exp_full || bus.rsp_ready;
      case (bus.req_valid)
        2'b01:   mon_gnt = 2'b01;
        2'b10:   mon_gnt = 2'b10;
        2'b11:   mon_gnt = exp_last ? 2'b01 : 2'b10;
        default: mon_gnt = 2'b00;
      endcase
      mon_req_ready_exp = mon_can ? mon_gnt : 2'b00;
      checks++;
      if (bus.req_ready !== mon_req_ready_exp) begin
        failures++;
        $display("FAIL mon_req_ready got=%b exp=%b", bus.req_ready, mon_req_ready_exp);
      end
      checks++;
      if (bus.rsp_valid !== exp_full) begin
        failures++;
        $display("FAIL mon_rsp_valid got=%b exp=%b", bus.rsp_valid, exp_full);
      end
      if (exp_full && q.size() > 0) begin
        mon_e = q[0];
        checks++;
        if (bus.rsp_id !== mon_e.id || bus.rsp_out !== mon_e.out ||
            bus.rsp_zero !== mon_e.zero || bus.rsp_illegal !== mon_e.illegal) begin
          failures++;
          $display("FAIL mon_rsp got id=%b out=%h z=%b il=%b exp id=%b out=%h z=%b il=%b",
                   bus.rsp_id, bus.rsp_out, bus.rsp_zero, bus.rsp_illegal,
                   mon_e.id, mon_e.out, mon_e.zero, mon_e.illegal);
        end
        if (bus.rsp_ready) void'(q.pop_front());
      end
      if (mon_gnt != 2'b00 && mon_can) begin
        mon_id = mon_gnt[1];
        q.push_back(model(mon_id, bus.req_ctrl[mon_id*4 +: 4],
                          bus.req_a[mon_id*W +: W], bus.req_b[mon_id*W +: W]));
        exp_full = 1'b1;
        exp_last = mon_id;
      end else if (bus.rsp_ready) begin
        exp_full = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [3:0] c,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_ctrl[i*4 +: 4] = c;
    bus.req_a[i*W +: W]    = a;
    bus.req_b[i*W +: W]    = b;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.req_valid = 2'b00;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 2'b00; bus.req_a = '0; bus.req_b = '0; bus.req_ctrl = '0;
    bus.rsp_ready = 1'b1;
    apply_reset();
    #2;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 1'b0 || bus.rsp_out !== '0 ||
        bus.rsp_zero !== 1'b0 || bus.rsp_illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b id=%b out=%h z=%b il=%b exp all 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_out, bus.rsp_zero, bus.rsp_illegal);
    end
    checks++;
    if (bus.req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready);
    end
    step();
  endtask

  task automatic test_single_op();
    drive_req(0, 4'b0010, 64'd5, 64'd7);
    bus.req_valid = 2'b01; bus.rsp_ready = 1'b1;
    #2;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++; $display("FAIL single_ready got=%b exp=01", bus.req_ready);
    end
    step();
    bus.req_valid = 2'b00;
    #2;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_out !== 64'd12 ||
        bus.rsp_zero !== 1'b0 || bus.rsp_illegal !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp got v=%b id=%b out=%h z=%b il=%b exp v=1 id=0 out=c z=0 il=0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_out, bus.rsp_zero, bus.rsp_illegal);
    end
    step();
    #2;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL single_drain got=%b exp=0", bus.rsp_valid);
    end
    step();
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy;
    apply_reset();
    drive_req(0, 4'b0110, 64'd9, 64'd9);
    drive_req(1, 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    bus.req_valid = 2'b11; bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (bus.req_ready !== exp_rdy) begin
        failures++; $display("FAIL contention_grant[%0d] got=%b exp=%b", k, bus.req_ready, exp_rdy);
      end
      if (k > 0) begin
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ((k % 2 == 0) ? 1'b1 : 1'b0) ||
            bus.rsp_out !== ((k % 2 == 0) ? 64'd1 : 64'd0) || bus.rsp_zero !== 1'b1) begin
          failures++;
          $display("FAIL contention_rsp[%0d] got v=%b id=%b out=%h z=%b", k,
                   bus.rsp_valid, bus.rsp_id, bus.rsp_out, bus.rsp_zero);
        end
      end
      step();
    end
    bus.req_valid = 2'b00;
    #2;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_out !== 64'd1 || bus.rsp_zero !== 1'b1) begin
      failures++;
      $display("FAIL contention_last got v=%b id=%b out=%h z=%b exp v=1 id=1 out=1 z=1",
               bus.rsp_valid, bus.rsp_id, bus.rsp_out, bus.rsp_zero);
    end
    step();
  endtask

  task automatic test_backpressure();
    drive_req(0, 4'b0001, 64'hF0, 64'h0F);
    bus.req_valid = 2'b01; bus.rsp_ready = 1'b1;
    step();
    drive_req(0, 4'b0010, 64'd1, 64'd2);
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_out !== 64'hFF || bus.req_ready !== 2'b00) begin
        failures++;
        $display("FAIL backpressure[%0d] got v=%b out=%h rdy=%b exp v=1 out=ff rdy=00", k,
                 bus.rsp_valid, bus.rsp_out, bus.req_ready);
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    #2;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++; $display("FAIL release_accept got=%b exp=01", bus.req_ready);
    end
    step();
    bus.req_valid = 2'b00;
    #2;
    checks++;
    if (bus.rsp_out !== 64'd3 || bus.rsp_valid !== 1'b1) begin
      failures++; $display("FAIL release_rsp got v=%b out=%h exp v=1 out=3", bus.rsp_valid, bus.rsp_out);
    end
    step();
  endtask

  task automatic test_wrap_illegal();
    drive_req(0, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    bus.req_valid = 2'b01; bus.rsp_ready = 1'b1;
    step();
    drive_req(1, 4'b1111, 64'd5, 64'd5);
    bus.req_valid = 2'b10;
    #2;
    checks++;
    if (bus.rsp_out !== 64'd0 || bus.rsp_zero !== 1'b0 || bus.rsp_illegal !== 1'b0 || bus.rsp_id !== 1'b0) begin
      failures++;
      $display("FAIL wrap_add got out=%h z=%b il=%b id=%b exp out=0 z=0 il=0 id=0",
               bus.rsp_out, bus.rsp_zero, bus.rsp_illegal, bus.rsp_id);
    end
    step();
    bus.req_valid = 2'b00;
    #2;
    checks++;
    if (bus.rsp_out !== 64'd0 || bus.rsp_zero !== 1'b0 || bus.rsp_illegal !== 1'b1 || bus.rsp_id !== 1'b1) begin
      failures++;
      $display("FAIL illegal_op got out=%h z=%b il=%b id=%b exp out=0 z=0 il=1 id=1",
               bus.rsp_out, bus.rsp_zero, bus.rsp_illegal, bus.rsp_id);
    end
    step();
  endtask

  task automatic test_reset_mid();
    drive_req(1, 4'b0010, 64'd1, 64'd1);
    drive_req(0, 4'b0010, 64'd4, 64'd4);
    bus.req_valid = 2'b10; bus.rsp_ready = 1'b0;
    step();
    bus.req_valid = 2'b01; bus.rsp_ready = 1'b1;
    reset = 1'b1;
    #2;
    checks++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_before got rdy=%b v=%b exp rdy=00 v=1", bus.req_ready, bus.rsp_valid);
    end
    step();
    reset = 1'b0;
    bus.req_valid = 2'b11;
    #2;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_out !== '0) begin
      failures++;
      $display("FAIL reset_mid_cleared got v=%b out=%h exp v=0 out=0", bus.rsp_valid, bus.rsp_out);
    end
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++; $display("FAIL reset_mid_rr got=%b exp=01", bus.req_ready);
    end
    step();
    bus.req_valid = 2'b00;
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [6];
    logic [W-1:0] a, b;
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010;
    ops[3] = 4'b0110; ops[4] = 4'b0111; ops[5] = 4'b1011;
    for (int k = 0; k < 80; k++) begin
      for (int r = 0; r < 2; r++) begin
        a = {$urandom, $urandom};
        b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
        drive_req(r, ops[$urandom_range(0, 5)], a, b);
      end
      bus.req_valid = 2'($urandom_range(0, 3));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.req_valid = 2'b00; bus.rsp_ready = 1'b1;
    step(); step(); step();
    #2;
    checks++;
    if (q.size() != 0 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain got pending=%0d v=%b exp pending=0 v=0", q.size(), bus.rsp_valid);
    end
    step();
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic test_perf();
    apply_reset();
    drive_req(0, 4'b0010, 64'd1, 64'd1);
    drive_req(1, 4'b0000, 64'd3, 64'd1);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b01;
    for (int k = 0; k < 5; k++) step();
    bus.req_valid = 2'b10;
    for (int k = 0; k < 3; k++) step();
    bus.req_valid = 2'b01; bus.rsp_ready = 1'b0;
    step(); step();
    bus.req_valid = 2'b00; bus.rsp_ready = 1'b1;
    #2;
    checks++;
    if (perf_grant0 !== 32'd5 || perf_grant1 !== 32'd3 || perf_stall !== 32'd2) begin
      failures++;
      $display("FAIL perf got g0=%0d g1=%0d st=%0d exp 5 3 2", perf_grant0, perf_grant1, perf_stall);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_wrap_illegal();
    test_reset_mid();
    test_back_to_back();
`ifdef ALU_ARB_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
